// File: rtl/i2c_mem_slave_pkg.sv
// Shared types and constants for the I2C memory slave and its line conditioner.
package i2c_mem_slave_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        MEM_ADDR,
        MEM_ACK,
        WR_DATA,
        WR_ACK,
        RD_FETCH,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic [3:0] CHUNK_SIZE = 4'd8;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// scl/sda conditioning: 2-FF sync, optional 3-sample majority filter (I2C_GLITCH_FILTER_EN),
// scl edge detection and START/STOP decode.
module i2c_line_cond
    import i2c_mem_slave_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);
    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_p_q, sda_p_q;
    logic scl_c, sda_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
            scl_p_q  <= scl_c;
            sda_p_q  <= sda_c;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic scl_h1_q, scl_h2_q, sda_h1_q, sda_h2_q, scl_f_q, sda_f_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_h1_q <= 1'b1;
            scl_h2_q <= 1'b1;
            sda_h1_q <= 1'b1;
            sda_h2_q <= 1'b1;
            scl_f_q  <= 1'b1;
            sda_f_q  <= 1'b1;
        end else begin
            scl_h1_q <= scl_s2_q;
            scl_h2_q <= scl_h1_q;
            sda_h1_q <= sda_s2_q;
            sda_h2_q <= sda_h1_q;
            scl_f_q  <= maj3(scl_s2_q, scl_h1_q, scl_h2_q);
            sda_f_q  <= maj3(sda_s2_q, sda_h1_q, sda_h2_q);
        end
    end

    assign scl_c = scl_f_q;
    assign sda_c = sda_f_q;
`else
    assign scl_c = scl_s2_q;
    assign sda_c = sda_s2_q;
`endif

    // START/STOP need scl stable high across the sample pair, so a joint scl+sda change is data.
    assign scl_rise_o = scl_c & ~scl_p_q;
    assign scl_fall_o = ~scl_c & scl_p_q;
    assign sda_o      = sda_c;
    assign start_o    = scl_c & scl_p_q & sda_p_q & ~sda_c;
    assign stop_o     = scl_c & scl_p_q & ~sda_p_q & sda_c;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C slave bridging the bus pins to a single-port memory: device/memory addressing, burst
// writes and reads with pointer auto-increment. Build option: I2C_GLITCH_FILTER_EN.
module i2c_mem_slave
    import i2c_mem_slave_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter int         DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);
    localparam int         NB      = DATA_W / 8;
    localparam int         NAB     = (ADDR_W + 7) / 8;
    localparam logic [3:0] NB_M1   = 4'(NB - 1);
    localparam logic [3:0] NAB_M1  = 4'(NAB - 1);
    localparam logic [3:0] ACK_BIT = CHUNK_SIZE + 4'd1;

    logic scl_rise, scl_fall, sda_c, start, stop;

    i2c_line_cond u_line_cond (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_o      (sda_c),
        .start_o    (start),
        .stop_o     (stop)
    );

    i2c_state_t        state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              fetch_q, fetch_d;
    logic [7:0]        sh_q, sh_d;
    logic [DATA_W-1:0] wacc_q, wacc_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              rw_q, rw_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            fetch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            fetch_q    <= fetch_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q   <= sh_d;
        wacc_q <= wacc_d;
        rbuf_q <= rbuf_d;
        rw_q   <= rw_d;
    end

    // Protocol transitions happen on scl fall, so every sda_oe change lands in the low phase.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        fetch_d    = 1'b0;
        sh_d       = sh_q;
        wacc_d     = wacc_q;
        rbuf_d     = rbuf_q;
        rw_d       = rw_q;

        if (wr_q) addr_d = addr_q + ADDR_W'(1);
        if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d    = DEV_ADDR;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            unique case (state_q)
                DEV_ADDR: if (scl_fall && bit_cnt_q == CHUNK_SIZE) begin
                    if (sh_q[7:1] == SLV_ADDR) begin
                        state_d = DEV_ACK;
                        rw_d    = sh_q[0];
                    end else begin
                        state_d = WAIT_STOP;
                    end
                end
                DEV_ACK: if (scl_fall && bit_cnt_q == ACK_BIT) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    state_d    = rw_q ? RD_FETCH : MEM_ADDR;
                end
                MEM_ADDR: if (scl_fall && bit_cnt_q == CHUNK_SIZE) begin
                    addr_d     = (addr_q << 8) | ADDR_W'(sh_q);
                    byte_cnt_d = (byte_cnt_q == NAB_M1) ? 4'd0 : byte_cnt_q + 4'd1;
                    state_d    = MEM_ACK;
                end
                MEM_ACK: if (scl_fall && bit_cnt_q == ACK_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = (byte_cnt_q == 4'd0) ? WR_DATA : MEM_ADDR;
                end
                WR_DATA: if (scl_fall && bit_cnt_q == CHUNK_SIZE) begin
                    wacc_d  = (wacc_q << 8) | DATA_W'(sh_q);
                    state_d = WR_ACK;
                    if (byte_cnt_q == NB_M1) begin
                        byte_cnt_d = '0;
                        wr_d       = 1'b1;
                        wdata_d    = (wacc_q << 8) | DATA_W'(sh_q);
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
                WR_ACK: if (scl_fall && bit_cnt_q == ACK_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = WR_DATA;
                end
                RD_FETCH: begin
                    if (!fetch_q) begin
                        fetch_d = 1'b1;
                    end else begin
                        rbuf_d  = rdata;
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    rbuf_d = rbuf_q << 1;
                    if (bit_cnt_q == CHUNK_SIZE) state_d = RD_ACK;
                end
                RD_ACK: if (scl_fall && bit_cnt_q == ACK_BIT) begin
                    bit_cnt_d = '0;
                    if (sh_q[0] != ACK) begin
                        state_d = WAIT_STOP;
                    end else if (byte_cnt_q == NB_M1) begin
                        byte_cnt_d = '0;
                        addr_d     = addr_q + ADDR_W'(1);
                        state_d    = RD_FETCH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                        state_d    = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_oe = ~NACK;
        rd_en  = 1'b0;
        unique case (state_q)
            DEV_ACK, MEM_ACK, WR_ACK: sda_oe = ~ACK;
            RD_DATA:                  sda_oe = ~rbuf_q[DATA_W-1];
            RD_FETCH:                 rd_en  = ~fetch_q;
            default: ;
        endcase
        wr_en = wr_q;
        addr  = addr_q;
        wdata = wdata_q;
        busy  = (state_q != IDLE);
    end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench: an 8-bit and a 16-bit slave share one bus (addresses 0x50 / 0x51).
module tb_i2c_mem_slave;
    localparam int Q = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, scl_m, sda_m, sda_bus;
    logic sda_oe8, wr8, rd8, busy8;
    logic [7:0] addr8, wdata8, rdata8;
    logic sda_oe16, wr16, rd16, busy16;
    logic [7:0]  addr16;
    logic [15:0] wdata16;
    logic [15:0] rdata16 = 16'hBEEF;

    assign sda_bus = sda_m & ~sda_oe8 & ~sda_oe16;

    i2c_mem_slave #(.SLV_ADDR(7'h50), .ADDR_W(8), .DATA_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe8),
        .wr_en(wr8), .rd_en(rd8), .addr(addr8), .wdata(wdata8), .rdata(rdata8), .busy(busy8)
    );

    i2c_mem_slave #(.SLV_ADDR(7'h51), .ADDR_W(8), .DATA_W(16)) u_dut16 (
        .clk(clk), .reset(reset), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe16),
        .wr_en(wr16), .rd_en(rd16), .addr(addr16), .wdata(wdata16), .rdata(rdata16), .busy(busy16)
    );

    logic [7:0]  mem8 [256];
    logic [7:0]  wa8 [64];
    logic [7:0]  wd8 [64];
    logic [7:0]  wa16 [64];
    logic [15:0] wd16 [64];
    int wr8_n = 0, rd8_n = 0, wr16_n = 0, oe_n = 0, both_n = 0, busy_n = 0;

    always @(posedge clk) begin
        if (rd8) rdata8 <= mem8[addr8];
        if (wr8) begin
            wa8[wr8_n[5:0]] <= addr8;
            wd8[wr8_n[5:0]] <= wdata8;
            wr8_n <= wr8_n + 1;
        end
        if (wr16) begin
            wa16[wr16_n[5:0]] <= addr16;
            wd16[wr16_n[5:0]] <= wdata16;
            wr16_n <= wr16_n + 1;
        end
        if (rd8) rd8_n <= rd8_n + 1;
        if (sda_oe8 | sda_oe16) oe_n <= oe_n + 1;
        if ((wr8 & rd8) | (wr16 & rd16)) both_n <= both_n + 1;
        if (busy8) busy_n <= busy_n + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wbit(input logic b, output logic s);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(Q);
        s = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) wbit(v[i], s);
        wbit(1'b1, s);
        acked = ~s;
    endtask

    task automatic rbyte(input logic mack_bit, output logic [7:0] v);
        logic s;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            wbit(1'b1, s);
            v = {v[6:0], s};
        end
        wbit(mack_bit, s);
    endtask

    logic       a0, a1, a2, a3, a4;
    logic [7:0] b0, b1;
    int         w0, r0, o0, y0;

    initial begin
        for (int i = 0; i < 256; i++) mem8[i] = 8'(i ^ 8'hC3);
        mem8[8'h00] = 8'h77;
        mem8[8'h20] = 8'h33;
        mem8[8'h21] = 8'h44;
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(2);
        check_eq("rst_sda_oe", sda_oe8, 1'b0);
        check_eq("rst_wr_en", wr8, 1'b0);
        check_eq("rst_rd_en", rd8, 1'b0);
        check_eq("rst_addr", addr8, 8'h00);
        check_eq("rst_wdata", wdata8, 8'h00);
        check_eq("rst_busy", busy8, 1'b0);

        // read straight after reset uses pointer 0
        r0 = rd8_n;
        i2c_start;
        wbyte(8'hA1, a0);
        rbyte(1'b1, b0);
        i2c_stop;
        check_eq("rd0_ack", a0, 1'b1);
        check_eq("rd0_data", b0, 8'h77);
        check_eq("rd0_rd_cnt", rd8_n - r0, 1);

        // single write
        w0 = wr8_n;
        i2c_start;
        check_eq("wr_busy_start", busy8, 1'b1);
        wbyte(8'hA0, a0);
        wbyte(8'h10, a1);
        wbyte(8'h5A, a2);
        i2c_stop;
        check_eq("wr_acks", {a0, a1, a2}, 3'b111);
        check_eq("wr_cnt", wr8_n - w0, 1);
        check_eq("wr_addr", wa8[w0[5:0]], 8'h10);
        check_eq("wr_data", wd8[w0[5:0]], 8'h5A);
        check_eq("wr_ptr_after", addr8, 8'h11);
        check_eq("wr_busy_stop", busy8, 1'b0);

        // burst across the address wrap
        w0 = wr8_n;
        i2c_start;
        wbyte(8'hA0, a0);
        wbyte(8'hFF, a1);
        wbyte(8'h11, a2);
        wbyte(8'h22, a3);
        i2c_stop;
        check_eq("burst_acks", {a0, a1, a2, a3}, 4'b1111);
        check_eq("burst_cnt", wr8_n - w0, 2);
        check_eq("burst_addr0", wa8[w0[5:0]], 8'hFF);
        check_eq("burst_data0", wd8[w0[5:0]], 8'h11);
        check_eq("burst_addr1", wa8[(w0 + 1) & 63], 8'h00);
        check_eq("burst_data1", wd8[(w0 + 1) & 63], 8'h22);
        check_eq("burst_ptr_after", addr8, 8'h01);

        // random-address read with repeated START
        w0 = wr8_n; r0 = rd8_n;
        i2c_start;
        wbyte(8'hA0, a0);
        wbyte(8'h20, a1);
        i2c_start;
        wbyte(8'hA1, a2);
        rbyte(1'b0, b0);
        rbyte(1'b1, b1);
        i2c_stop;
        check_eq("rd_acks", {a0, a1, a2}, 3'b111);
        check_eq("rd_byte0", b0, 8'h33);
        check_eq("rd_byte1", b1, 8'h44);
        check_eq("rd_rd_cnt", rd8_n - r0, 2);
        check_eq("rd_wr_cnt", wr8_n - w0, 0);
        check_eq("rd_ptr_after", addr8, 8'h21);

        // address mismatch: nobody answers
        w0 = wr8_n; r0 = rd8_n; o0 = oe_n;
        i2c_start;
        wbyte(8'h90, a0);
        wbyte(8'h12, a1);
        i2c_stop;
        check_eq("mis_acks", {a0, a1}, 2'b00);
        check_eq("mis_oe_cycles", oe_n - o0, 0);
        check_eq("mis_strobes", (wr8_n - w0) + (rd8_n - r0), 0);
        check_eq("mis_busy", busy8, 1'b0);

        // 16-bit words: partial word discarded, full word written MSB byte first
        w0 = wr16_n;
        i2c_start;
        wbyte(8'hA2, a0);
        wbyte(8'h04, a1);
        wbyte(8'hAB, a2);
        i2c_stop;
        check_eq("w16_part_acks", {a0, a1, a2}, 3'b111);
        check_eq("w16_part_cnt", wr16_n - w0, 0);
        i2c_start;
        wbyte(8'hA2, a0);
        wbyte(8'h04, a1);
        wbyte(8'hAB, a2);
        wbyte(8'hCD, a3);
        i2c_stop;
        check_eq("w16_cnt", wr16_n - w0, 1);
        check_eq("w16_addr", wa16[w0[5:0]], 8'h04);
        check_eq("w16_data", wd16[w0[5:0]], 16'hABCD);
        check_eq("w16_ptr_after", addr16, 8'h05);

        // reset in the middle of a data byte
        w0 = wr8_n;
        i2c_start;
        wbyte(8'hA0, a0);
        wbyte(8'h30, a1);
        for (int i = 0; i < 4; i++) wbit(1'b1, a4);
        check_eq("mid_busy_pre", busy8, 1'b1);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_outs", {sda_oe8, wr8, rd8, busy8}, 4'b0000);
        check_eq("mid_rst_addr", addr8, 8'h00);
        check_eq("mid_rst_wdata", wdata8, 8'h00);
        reset = 1'b0;
        i2c_stop;
        check_eq("mid_rst_wr_cnt", wr8_n - w0, 0);

        // one-clock sda dip while scl is high and the bus idle
        tick(4);
        y0 = busy_n;
        sda_m = 1'b0; tick(1);
        sda_m = 1'b1; tick(12);
`ifdef I2C_GLITCH_FILTER_EN
        check_eq("glitch_busy_cycles", busy_n - y0, 0);
`else
        check_eq("glitch_busy_cycles", busy_n - y0, 1);
`endif
        check_eq("glitch_busy_end", busy8, 1'b0);

        check_eq("wr_rd_overlap", both_n, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
